// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Imported by the priority selector and by the arbiter top level.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_D
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch and data, plus the saturating data-streak counter.
// Data has priority until it has won MAX_DATA_STREAK times in a row over a waiting fetch.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic       if_gnt_i,
  input  logic       d_gnt_i,
  output arb_owner_t owner_o
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DATA_STREAK);

  logic [3:0] streak_q, streak_d;

  always_comb begin
    owner_o = OWN_NONE;
    if (d_req_i && (streak_q < MaxStreak)) begin
      owner_o = OWN_D;
    end else if (if_req_i) begin
      owner_o = OWN_IF;
    end else if (d_req_i) begin
      owner_o = OWN_D;
    end
  end

  // The streak only grows while a fetch is actually left waiting behind the data grant.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt_i) begin
      streak_d = '0;
    end else if (d_gnt_i) begin
      if (!if_req_i) begin
        streak_d = '0;
      end else if (streak_q < MaxStreak) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one outstanding
// transaction at a time, routing each response back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  arb_state_t state_q, state_d;
  arb_owner_t winner;

  mem_arb_priority #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_priority (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .if_req_i(if_req_i),
    .d_req_i (d_req_i),
    .if_gnt_i(if_gnt_o),
    .d_gnt_i (d_gnt_o),
    .owner_o (winner)
  );

  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;
  assign busy_o     = (state_q != IDLE);

  // Requests are only issued from IDLE; a response in IDLE has no owner and is dropped.
  always_comb begin
    state_d     = state_q;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        case (winner)
          OWN_IF: begin
            mem_req_o  = 1'b1;
            mem_be_o   = FETCH_BE;
            mem_addr_o = if_addr_i;
          end
          OWN_D: begin
            mem_req_o   = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
          end
          default: ;
        endcase
        if (mem_req_o && mem_gnt_i) begin
          if (winner == OWN_IF) begin
            if_gnt_o = 1'b1;
            state_d  = WAIT_IF;
          end else begin
            d_gnt_o = 1'b1;
            state_d = WAIT_D;
          end
        end
      end
      WAIT_IF: begin
        if (mem_rvalid_i) begin
          if_rvalid_o = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          d_rvalid_o = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, dReq, dWe, memGnt, memRvalid;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;
  logic [3:0]  dBe;
  logic        ifGnt, ifRvalid, dGnt, dRvalid, memReq, memWe, busy;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata;
  logic [3:0]  memBe;

  int assertCount = 0;
  int failCount = 0;

  // Reference model: owner of the outstanding transaction (0 none, 1 fetch, 2 data)
  // and the number of back-to-back data wins over a waiting fetch.
  int mPending;
  int mStreak;
  logic ifGntSeen, dGntSeen;
  logic obsIfGnt, obsDGnt;
  logic [5:0] grantTrace;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_DATA_STREAK(MaxStreak)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (ifReq),
    .if_addr_i   (ifAddr),
    .if_gnt_o    (ifGnt),
    .if_rvalid_o (ifRvalid),
    .if_rdata_o  (ifRdata),
    .d_req_i     (dReq),
    .d_we_i      (dWe),
    .d_be_i      (dBe),
    .d_addr_i    (dAddr),
    .d_wdata_i   (dWdata),
    .d_gnt_o     (dGnt),
    .d_rvalid_o  (dRvalid),
    .d_rdata_o   (dRdata),
    .mem_req_o   (memReq),
    .mem_we_o    (memWe),
    .mem_be_o    (memBe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_gnt_i   (memGnt),
    .mem_rvalid_i(memRvalid),
    .mem_rdata_i (memRdata),
    .busy_o      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Predicts every output for the current inputs, compares, advances the model, then moves to the next cycle.
  task automatic stepCycle();
    int winner;
    int nextPending;
    int nextStreak;
    logic eReq, eWe, eIfGnt, eDGnt, eIfRv, eDRv;
    logic [3:0] eBe;
    logic [31:0] eAddr, eWdata;
    #2;
    winner = 0;
    nextPending = mPending;
    nextStreak = mStreak;
    eReq = 0; eWe = 0; eIfGnt = 0; eDGnt = 0; eIfRv = 0; eDRv = 0;
    eBe = 4'h0; eAddr = 32'h0; eWdata = 32'h0;
    if (mPending == 0) begin
      if (dReq && mStreak < MaxStreak) winner = 2;
      else if (ifReq) winner = 1;
      else if (dReq) winner = 2;
      if (winner == 1) begin
        eReq = 1; eBe = 4'hF; eAddr = ifAddr;
        if (memGnt) begin
          eIfGnt = 1; nextPending = 1; nextStreak = 0;
        end
      end else if (winner == 2) begin
        eReq = 1; eWe = dWe; eBe = dBe; eAddr = dAddr; eWdata = dWdata;
        if (memGnt) begin
          eDGnt = 1; nextPending = 2;
          nextStreak = ifReq ? ((mStreak + 1 > MaxStreak) ? MaxStreak : mStreak + 1) : 0;
        end
      end
    end else if (memRvalid) begin
      eIfRv = (mPending == 1);
      eDRv = (mPending == 2);
      nextPending = 0;
    end
    checkOutput("mem_req", 32'(memReq), 32'(eReq));
    checkOutput("mem_we", 32'(memWe), 32'(eWe));
    checkOutput("mem_be", 32'(memBe), 32'(eBe));
    checkOutput("mem_addr", memAddr, eAddr);
    checkOutput("mem_wdata", memWdata, eWdata);
    checkOutput("if_gnt", 32'(ifGnt), 32'(eIfGnt));
    checkOutput("d_gnt", 32'(dGnt), 32'(eDGnt));
    checkOutput("if_rvalid", 32'(ifRvalid), 32'(eIfRv));
    checkOutput("d_rvalid", 32'(dRvalid), 32'(eDRv));
    checkOutput("if_rdata", ifRdata, memRdata);
    checkOutput("d_rdata", dRdata, memRdata);
    checkOutput("busy", 32'(busy), 32'(mPending != 0));
    obsIfGnt = ifGnt;
    obsDGnt = dGnt;
    ifGntSeen = eIfGnt;
    dGntSeen = eDGnt;
    mPending = nextPending;
    mStreak = nextStreak;
    @(posedge clk);
    #1;
  endtask

  // Requesters keep a request and its attributes stable until granted, then may issue a new one.
  task automatic applyStimulus();
    if (!ifReq || ifGntSeen) begin
      ifReq = ($urandom_range(0, 99) < 55);
      ifAddr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dReq || dGntSeen) begin
      dReq = ($urandom_range(0, 99) < 55);
      dWe = 1'($urandom_range(0, 1));
      dBe = 4'($urandom_range(0, 15));
      dAddr = $urandom;
      dWdata = $urandom;
    end
    memGnt = ($urandom_range(0, 99) < 65);
    memRvalid = (mPending != 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 15);
    memRdata = $urandom;
  endtask

  task automatic doReset();
    ifReq = 0; dReq = 0; dWe = 0; dBe = 4'h0; memGnt = 0; memRvalid = 0;
    ifGntSeen = 0; dGntSeen = 0;
    rst = 1;
    mPending = 0;
    mStreak = 0;
    stepCycle();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    ifReq = 0; ifAddr = 32'h0;
    dReq = 0; dWe = 0; dBe = 4'h0; dAddr = 32'h0; dWdata = 32'h0;
    memGnt = 0; memRvalid = 0; memRdata = 32'h1234_5678;
    mPending = 0; mStreak = 0;
    ifGntSeen = 0; dGntSeen = 0; obsIfGnt = 0; obsDGnt = 0;
    @(posedge clk);
    #1;
    stepCycle();
    rst = 0;

    $display("[TB] single fetch");
    ifReq = 1; ifAddr = 32'h100; memGnt = 1;
    stepCycle();
    ifReq = 0; memGnt = 0;
    stepCycle();
    stepCycle();
    memRvalid = 1; memRdata = 32'h0050_0093;
    stepCycle();
    memRvalid = 0;

    $display("[TB] simultaneous fetch and data write");
    ifReq = 1; ifAddr = 32'h104;
    dReq = 1; dWe = 1; dBe = 4'b0011; dAddr = 32'h2000; dWdata = 32'hDEAD_BEEF;
    memGnt = 1;
    stepCycle();
    dReq = 0; memRvalid = 1; memRdata = 32'h0;
    stepCycle();
    memRvalid = 0;
    stepCycle();
    ifReq = 0; memRvalid = 1; memRdata = 32'h0000_0013;
    stepCycle();
    memRvalid = 0;

    $display("[TB] starvation bound");
    grantTrace = '0;
    ifReq = 1; dReq = 1; dWe = 0; dBe = 4'hF; memGnt = 1;
    for (int i = 0; i < 12; i++) begin
      if (ifGntSeen) ifAddr = ifAddr + 32'h4;
      if (dGntSeen) dAddr = 32'h8000 + 32'(i * 4);
      memRvalid = (mPending != 0);
      memRdata = $urandom;
      stepCycle();
      if (obsIfGnt || obsDGnt) grantTrace = {grantTrace[4:0], obsIfGnt};
    end
    checkOutput("starve_seq", 32'(grantTrace), 32'(6'b000010));
    ifReq = 0; dReq = 0; memGnt = 0; memRvalid = 0;

    $display("[TB] spurious response in idle");
    memRvalid = 1; memRdata = 32'hCAFE_F00D;
    stepCycle();
    stepCycle();
    memRvalid = 0;

    $display("[TB] reset mid-transaction");
    dReq = 1; dWe = 0; dBe = 4'hF; dAddr = 32'h3000; memGnt = 1;
    stepCycle();
    dReq = 0; memGnt = 0;
    stepCycle();
    doReset();
    memRvalid = 1;
    stepCycle();
    memRvalid = 0;

    $display("[TB] memory backpressure");
    dReq = 1; dWe = 1; dBe = 4'b1100; dAddr = 32'h4444_0000; dWdata = 32'h5555_AAAA; memGnt = 0;
    repeat (5) stepCycle();
    memGnt = 1;
    stepCycle();
    dReq = 0; memGnt = 0; memRvalid = 1;
    stepCycle();
    memRvalid = 0;

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        applyStimulus();
        stepCycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single unified memory port between the core's instruction-fetch requester and its load/store requester, so the pipeline can run from one single-ported RAM/bus instead of separate instruction and data memories. It sits between `riscv_core` and the memory/peripheral interconnect. It grants one requester at a time, tracks the single outstanding transaction, and routes the response back to its owner. Priority is fixed with data first, with a bounded-streak rule that prevents fetch starvation.

## Interface
- `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while a fetch is pending, before fetch is forced to win. Legal range 1..15.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `if_req_i`  in  1  fetch request.
- `if_addr_i`  in  32  fetch address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch response valid.
- `if_rdata_o`  out  32  fetch read data.
- `d_req_i`  in  1  data request.
- `d_we_i`  in  1  data write enable.
- `d_be_i`  in  4  data byte enables.
- `d_addr_i`  in  32  data address.
- `d_wdata_i`  in  32  data write data.
- `d_gnt_o`  out  1  data request accepted.
- `d_rvalid_o`  out  1  data response valid; also acknowledges writes.
- `d_rdata_o`  out  32  data read data.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  memory write enable.
- `mem_be_o`  out  4  memory byte enables.
- `mem_addr_o`  out  32  memory address.
- `mem_wdata_o`  out  32  memory write data.
- `mem_gnt_i`  in  1  memory accepted the request.
- `mem_rvalid_i`  in  1  memory response; exactly one per accepted request, including writes.
- `mem_rdata_i`  in  32  memory read data.
- `busy_o`  out  1  a transaction is outstanding.

## Operation
- **Handshake:** a requester holds `req` and all of its attributes stable until it sees `gnt`. Withdrawing a request before grant is illegal.
- **FSM states:** `IDLE`, `WAIT_IF`, `WAIT_D`.
- **`IDLE`, owner selection (combinational):**
  - Data wins if `d_req_i` is high and `streak < MAX_DATA_STREAK`.
  - Otherwise fetch wins if `if_req_i` is high.
  - Otherwise data wins if `d_req_i` is high.
- **`IDLE`, memory drive:** `mem_req_o` is high when a winner exists. `mem_*` carry the winner's attributes; on a fetch, `mem_we_o`=0 and `mem_be_o`=4'hF. With no winner, `mem_*` are all 0.
- **`IDLE`, grant:** when `mem_gnt_i` and `mem_req_o` are both high, the winner's `gnt` goes high in the same cycle. The state then moves to `WAIT_IF` or `WAIT_D`.
- **`WAIT_x`:**
  - `mem_req_o`=0, and `mem_gnt_i` is ignored.
  - When `mem_rvalid_i` arrives, the owner's `rvalid` goes high combinationally and the state returns to `IDLE`.
- **Read data:** `if_rdata_o` and `d_rdata_o` both mirror `mem_rdata_i` at all times. Only the `rvalid` signals are qualified by owner.
- **Streak counter (4-bit):**
  - On a data grant while `if_req_i` is high: increment, saturating at `MAX_DATA_STREAK`.
  - On a data grant while `if_req_i` is low: clear to 0.
  - On a fetch grant: clear to 0.
- **Boundary cases:**
  - `mem_rvalid_i` in `IDLE` is spurious: ignored, with no output effect.
  - Reset mid-transaction abandons the transaction. A late `rvalid` after reset is ignored because the FSM is in `IDLE`.
  - Simultaneous `if_req_i` and `d_req_i` with `streak`==`MAX_DATA_STREAK`: fetch wins.
- `busy_o` = (state != `IDLE`).

## Timing
- **Reset values:** state `IDLE`, `streak` 0. All outputs are 0 except `*_rdata_o`, which follow `mem_rdata_i`.
- **Latency:** grant is 0 cycles after `mem_gnt_i`. Response is 0 cycles after `mem_rvalid_i`.
- **Minimum throughput:** one transaction every 2 cycles (grant cycle, then response cycle). The next grant is possible in the cycle after `rvalid`.
- Only the state and `streak` registers are clocked. All port outputs are combinational from state and inputs.

## Structure
- **Package `mem_arb_pkg`:**
  - `arb_state_t` enum (`IDLE`, `WAIT_IF`, `WAIT_D`).
  - `arb_owner_t` enum (`OWN_NONE`, `OWN_IF`, `OWN_D`).
  - Constant `FETCH_BE` = 4'hF.
- **Sub-module `mem_arb_priority`:** combinational winner select plus the saturating streak register. The top level holds the FSM and the muxes.

## Test plan
- **Single fetch:** `if_req_i`=1, addr 0x100, `mem_gnt_i`=1, `rvalid` 3 cycles later with rdata 0x00500093 → `if_gnt_o` pulses in cycle 0, `if_rvalid_o` pulses in cycle 3 with that data, `busy_o` high in cycles 1–3.
- **Simultaneous requests:** fetch and a data write (addr 0x2000, wdata 0xDEADBEEF, be 4'b0011) at `streak` 0 → data granted first with `mem_we_o`=1, `mem_be_o`=4'b0011; fetch granted in the cycle after the data `rvalid`.
- **Starvation bound:** `MAX_DATA_STREAK`=4, with `d_req_i` and `if_req_i` held high → exactly 4 data grants, then 1 fetch grant, then data again.
- **Spurious response:** `mem_rvalid_i`=1 in `IDLE` → no `if_rvalid_o` or `d_rvalid_o`, state stays `IDLE`.
- **Reset mid-transaction:** assert `rst_i` in `WAIT_D`, release it, then present `mem_rvalid_i` → `d_rvalid_o` stays 0 and `busy_o`=0.
- **Memory backpressure:** `mem_gnt_i`=0 for 5 cycles with `d_req_i` held → `mem_req_o` held with stable address, `d_gnt_o` only in the cycle `mem_gnt_i` rises.
